i2s_capture_ctrl: RTL and testbench

//   Sequences an I2S microphone capture session on top of i2s_clock_gen.
//   - Holds the generator in reset when idle, releases it on start, and waits for frame lock.
//   - Discards a programmable number of warm-up frames, then deserialises sd_i into words.
//   - Presents words on a valid/ready stream and ends a session cleanly on a frame boundary.

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_shift_rx.sv | 70 +++++++
 rtl/i2s_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default constants for the I2S capture path.
package i2s_pkg;

  // Capture session sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WARMUP,
    RUN,
    DRAIN
  } cap_state_e;

  // Defaults matching the companion clock generator.
  localparam int I2S_SCKS_PER_FRAME = 32;
  localparam int I2S_SAMPLE_W       = 24;

  // Channel encoding follows WS: low half is left.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_shift_rx.sv
// I2S receive shifter: SCK/WS edge detection, per-half bit counter and an
// MSB-first shift register. Emits a one-cycle word_done_o strobe with the
// channel of the half the word belongs to.
module i2s_shift_rx
  import i2s_pkg::*;
#(
  parameter int SCKS_PER_FRAME = I2S_SCKS_PER_FRAME,
  parameter int SAMPLE_W       = I2S_SAMPLE_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sck_i,
  input  logic                ws_i,
  input  logic                sd_i,
  output logic [SAMPLE_W-1:0] word_o,
  output logic                word_done_o,
  output logic                ch_o,
  output logic                ws_edge_o
);

  localparam int              CNT_W    = $clog2(SCKS_PER_FRAME);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCKS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W);

  logic                sck_prev_reg;
  logic                ws_prev_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [SAMPLE_W-1:0] shift_reg;
  logic                done_reg;
  logic                ch_reg;
  logic                rise;

  assign rise      = sck_i & ~sck_prev_reg;
  assign ws_edge_o = ws_i ^ ws_prev_reg;

  // Edge history, bit counter (count 0 is the delay slot) and MSB-first shift.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_prev_reg <= 1'b0;
      ws_prev_reg  <= 1'b0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      done_reg     <= 1'b0;
      ch_reg       <= CH_LEFT;
    end else begin
      sck_prev_reg <= sck_i;
      ws_prev_reg  <= ws_i;
      done_reg     <= 1'b0;
      if (ws_edge_o) begin
        bit_cnt_reg <= '0;
      end else if (rise) begin
        if (bit_cnt_reg != CNT_MAX) begin
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
        if ((bit_cnt_reg != '0) && (bit_cnt_reg <= CNT_LAST)) begin
          shift_reg <= (shift_reg << 1) | SAMPLE_W'(sd_i);
        end
        if (bit_cnt_reg == CNT_LAST) begin
          done_reg <= 1'b1;
          ch_reg   <= ws_i;
        end
      end
    end
  end

  assign word_o      = shift_reg;
  assign word_done_o = done_reg;
  assign ch_o        = ch_reg;

endmodule

// File: rtl/i2s_capture_ctrl.sv
// I2S microphone capture session controller. Holds the clock generator in
// reset while idle, waits for frame lock, drops warm-up frames, then streams
// captured words on a valid/ready port with a sticky saturating overrun count.
// Build option: I2S_STEREO_EN emits both channels; otherwise left only.
module i2s_capture_ctrl
  import i2s_pkg::*;
#(
  parameter int SCKS_PER_FRAME = I2S_SCKS_PER_FRAME,
  parameter int SAMPLE_W       = I2S_SAMPLE_W,
  parameter int WARMUP_FRAMES  = 4,
  parameter int OVR_CNT_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic                 gen_rst_no,
  input  logic                 sck_i,
  input  logic                 ws_i,
  input  logic                 frame_start_i,
  input  logic                 sd_i,
  output logic [SAMPLE_W-1:0]  sample_o,
  output logic                 sample_ch_o,
  output logic                 sample_valid_o,
  input  logic                 sample_ready_i,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [OVR_CNT_W-1:0] ovr_cnt_o
);

  localparam int               WCNT_W    = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);

  cap_state_e          state_reg, state_next;
  logic [WCNT_W-1:0]   warm_cnt_reg;
  logic                half_ok_reg;
  logic [SAMPLE_W-1:0] sample_reg;
  logic                valid_reg;
  logic                overrun_reg;
  logic [OVR_CNT_W-1:0] ovr_cnt_reg;
  logic [SAMPLE_W-1:0] rx_word;
  logic                rx_done;
  logic                rx_ch;
  logic                rx_ws_edge;
  logic                capturing;
  logic                ch_ok;
  logic                push;

  i2s_shift_rx #(
    .SCKS_PER_FRAME(SCKS_PER_FRAME),
    .SAMPLE_W      (SAMPLE_W)
  ) u_shift_rx (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sck_i      (sck_i),
    .ws_i       (ws_i),
    .sd_i       (sd_i),
    .word_o     (rx_word),
    .word_done_o(rx_done),
    .ch_o       (rx_ch),
    .ws_edge_o  (rx_ws_edge)
  );

  assign capturing = (state_reg == RUN) || (state_reg == DRAIN);

`ifdef I2S_STEREO_EN
  logic sample_ch_reg;
  assign ch_ok       = 1'b1;
  assign sample_ch_o = sample_ch_reg;
`else
  assign ch_ok       = (rx_ch == CH_LEFT);
  assign sample_ch_o = CH_LEFT;
`endif

  assign push = rx_done && half_ok_reg && capturing && ch_ok;

  // State register plus warm-up frame counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      warm_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg != WARMUP) begin
        warm_cnt_reg <= '0;
      end else if (frame_start_i) begin
        warm_cnt_reg <= warm_cnt_reg + WCNT_W'(1);
      end
    end
  end

  // Next-state logic; stop beats frame_start while still locking.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_i) state_next = SYNC;
      SYNC: begin
        if (stop_i)             state_next = IDLE;
        else if (frame_start_i) state_next = (WARMUP_FRAMES == 0) ? RUN : WARMUP;
      end
      WARMUP: begin
        if (stop_i)                                       state_next = IDLE;
        else if (frame_start_i && warm_cnt_reg == WARM_LAST) state_next = RUN;
      end
      RUN:     if (stop_i)        state_next = DRAIN;
      DRAIN:   if (frame_start_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A half is eligible only if its WS change happened while capturing (or on entry to RUN).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      half_ok_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      half_ok_reg <= 1'b0;
    end else if (rx_ws_edge) begin
      half_ok_reg <= capturing || (state_next == RUN);
    end
  end

  // Output holding register with overrun detection; survives return to IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sample_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      ovr_cnt_reg <= '0;
`ifdef I2S_STEREO_EN
      sample_ch_reg <= CH_LEFT;
`endif
    end else begin
      if ((state_reg == IDLE) && start_i) begin
        overrun_reg <= 1'b0;
        ovr_cnt_reg <= '0;
      end
      if (push) begin
        if (!valid_reg || sample_ready_i) begin
          sample_reg <= rx_word;
          valid_reg  <= 1'b1;
`ifdef I2S_STEREO_EN
          sample_ch_reg <= rx_ch;
`endif
        end else begin
          overrun_reg <= 1'b1;
          if (ovr_cnt_reg != {OVR_CNT_W{1'b1}}) begin
            ovr_cnt_reg <= ovr_cnt_reg + OVR_CNT_W'(1);
          end
        end
      end else if (valid_reg && sample_ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign gen_rst_no     = (state_reg != IDLE);
  assign busy_o         = (state_reg != IDLE);
  assign sample_o       = sample_reg;
  assign sample_valid_o = valid_reg;
  assign overrun_o      = overrun_reg;
  assign ovr_cnt_o      = ovr_cnt_reg;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Bench for i2s_capture_ctrl: a behavioural I2S generator/microphone drives the
// DUT, queues the words it expects, and a stream monitor collects accepted words.
module tb_i2s_capture_ctrl;

  localparam int SCKS = 32;
  localparam int SW   = 24;
  localparam int W    = 2;
  localparam int OW   = 8;
`ifdef I2S_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni, start_i, stop_i, gen_rst_no;
  logic          sck, ws, fs, sd, ready;
  logic [SW-1:0] sample_o;
  logic          sample_ch_o, sample_valid_o, busy_o, overrun_o;
  logic [OW-1:0] ovr_cnt_o;

  logic [SW:0]   exp_q[$];
  logic [SW:0]   obs_q[$];
  logic [SW:0]   got, want;
  logic [SW-1:0] lw, rw, cur_l, cur_r, wsel;
  bit            inc_mode, stop_issued, cur_cap, ok;
  int            gcyc, frame_cnt, bitpos, k;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk_i = ~clk_i;

  i2s_capture_ctrl #(
    .SCKS_PER_FRAME(SCKS), .SAMPLE_W(SW), .WARMUP_FRAMES(W), .OVR_CNT_W(OW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .gen_rst_no(gen_rst_no), .sck_i(sck), .ws_i(ws), .frame_start_i(fs), .sd_i(sd),
    .sample_o(sample_o), .sample_ch_o(sample_ch_o), .sample_valid_o(sample_valid_o),
    .sample_ready_i(ready), .busy_o(busy_o), .overrun_o(overrun_o), .ovr_cnt_o(ovr_cnt_o)
  );

  // Generator + microphone model (queues expected words) and stream monitor.
  initial begin
    sck = 0; ws = 0; fs = 0; sd = 0; gcyc = 128; frame_cnt = -1;
    cur_l = '0; cur_r = '0; cur_cap = 0;
    forever begin
      @(negedge clk_i);
      if (!gen_rst_no) begin
        sck = 0; ws = 0; fs = 0; sd = 0; gcyc = 128; frame_cnt = -1; cur_cap = 0;
      end else begin
        fs = 1'b0;
        if (gcyc % 4 == 0) begin
          bitpos = gcyc / 4;
          sck = 1'b0;
          ws = (bitpos >= SCKS);
          if (bitpos == 0) begin
            frame_cnt++;
            fs = 1'b1;
            cur_l = lw; cur_r = rw;
            if (inc_mode) begin lw = lw + 1; rw = rw + 1; end
            cur_cap = (frame_cnt >= W) && !stop_issued;
            if (cur_cap) exp_q.push_back({1'b0, cur_l});
          end
          if (bitpos == SCKS && cur_cap && STEREO) exp_q.push_back({1'b1, cur_r});
          k = bitpos % SCKS;
          wsel = ws ? cur_r : cur_l;
          sd = (k >= 1 && k <= SW) ? wsel[SW-k] : 1'($urandom_range(0, 1));
        end else if (gcyc % 4 == 2) begin
          sck = 1'b1;
        end
        gcyc = (gcyc + 1) % (8 * SCKS);
      end
      #2;
      if (rst_ni && sample_valid_o && ready) obs_q.push_back({sample_ch_o, sample_o});
    end
  end

  task automatic do_start();
    @(negedge clk_i); #1; start_i = 1'b1; stop_issued = 0;
    @(negedge clk_i); #1; start_i = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk_i); #1; stop_i = 1'b1; stop_issued = 1;
    @(negedge clk_i); #1; stop_i = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit okay);
    okay = 0;
    for (int c = 0; c < 3000; c++) begin
      if (obs_q.size() >= n) begin okay = 1; break; end
      @(negedge clk_i); #3;
    end
    if (!okay) begin
      n_cmp++; n_err++;
      $display("FAIL wait_obs timeout: have %0d words, need %0d", obs_q.size(), n);
    end
  endtask

  task automatic wait_frame(input int n);
    bit okay = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_i); #1;
      if (frame_cnt >= n) begin okay = 1; break; end
    end
    if (!okay) begin
      n_cmp++; n_err++;
      $display("FAIL wait_frame timeout: frame %0d, need %0d", frame_cnt, n);
    end
  endtask

  task automatic wait_idle();
    bit okay = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i); #1;
      if (!busy_o) begin okay = 1; break; end
    end
    if (!okay) begin n_cmp++; n_err++; $display("FAIL wait_idle timeout busy=%b", busy_o); end
  endtask

  task automatic test_reset();
    rst_ni = 0; start_i = 0; stop_i = 0; ready = 1; lw = '0; rw = '0;
    inc_mode = 0; stop_issued = 0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({gen_rst_no, busy_o, sample_valid_o, overrun_o, sample_ch_o, ovr_cnt_o, sample_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs gen=%b busy=%b v=%b ovr=%b ch=%b cnt=%0d s=%h want all 0",
               gen_rst_no, busy_o, sample_valid_o, overrun_o, sample_ch_o, ovr_cnt_o, sample_o);
    end
    @(negedge clk_i); rst_ni = 1;
    repeat (4) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({gen_rst_no, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL idle_after_reset gen=%b busy=%b want 0 0", gen_rst_no, busy_o);
    end
  endtask

  task automatic test_capture();
    lw = 24'hA5A5A5; rw = 24'h5A5A5A; ready = 1;
    do_start();
    n_cmp++;
    if ({gen_rst_no, busy_o} !== 2'b11) begin
      n_err++; $display("FAIL t1_start gen=%b busy=%b want 1 1", gen_rst_no, busy_o);
    end
    wait_frame(W);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL t1_warmup_words got %0d want 0", obs_q.size());
    end
    repeat (20) @(negedge clk_i);
    do_stop();
    while (exp_q.size() > 0) begin
      wait_obs(1, ok);
      if (!ok) break;
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL t1_word got ch%b %h want ch%b %h", got[SW], got[SW-1:0], want[SW], want[SW-1:0]);
      end
    end
    wait_idle();
  endtask

  task automatic test_channels();
    lw = 24'h123456; rw = 24'hFEDCBA; ready = 1;
    do_start();
    wait_frame(W + 1);
    repeat (30) @(negedge clk_i);
    do_stop();
    n_cmp++;
    if (exp_q.size() != (STEREO ? 4 : 2)) begin
      n_err++; $display("FAIL t2_expected_count got %0d want %0d", exp_q.size(), STEREO ? 4 : 2);
    end
    while (exp_q.size() > 0) begin
      wait_obs(1, ok);
      if (!ok) break;
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL t2_word got ch%b %h want ch%b %h", got[SW], got[SW-1:0], want[SW], want[SW-1:0]);
      end
    end
    wait_idle();
    repeat (300) @(negedge clk_i);
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL t2_extra_words got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_overrun();
    bit okay = 0;
    lw = 24'h100001; rw = 24'h200001; inc_mode = 1; ready = 0;
    do_start();
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_i); #1;
      if (exp_q.size() >= 4) begin okay = 1; break; end
    end
    n_cmp++;
    if (!okay) begin n_err++; $display("FAIL t3_push_timeout got %0d pushes want 4", exp_q.size()); end
    n_cmp++;
    if ({sample_valid_o, sample_ch_o, sample_o} !== {1'b1, exp_q[0]}) begin
      n_err++; $display("FAIL t3_held_word got v%b ch%b %h want v1 ch%b %h",
                        sample_valid_o, sample_ch_o, sample_o, exp_q[0][SW], exp_q[0][SW-1:0]);
    end
    n_cmp++;
    if ({overrun_o, ovr_cnt_o} !== {1'b1, 8'd2}) begin
      n_err++; $display("FAIL t3_overrun got ovr=%b cnt=%0d want 1 2", overrun_o, ovr_cnt_o);
    end
    do_stop();
    ready = 1; inc_mode = 0;
    wait_obs(1, ok);
    if (ok) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL t3_first_word got ch%b %h want ch%b %h", got[SW], got[SW-1:0], want[SW], want[SW-1:0]);
      end
    end
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    while (exp_q.size() > 0) begin
      wait_obs(1, ok);
      if (!ok) break;
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL t3_word got ch%b %h want ch%b %h", got[SW], got[SW-1:0], want[SW], want[SW-1:0]);
      end
    end
    wait_idle();
    n_cmp++;
    if ({overrun_o, ovr_cnt_o} !== {1'b1, 8'd2}) begin
      n_err++; $display("FAIL t3_sticky got ovr=%b cnt=%0d want 1 2", overrun_o, ovr_cnt_o);
    end
  endtask

  task automatic test_stop_warmup();
    lw = 24'h777777; rw = 24'h888888; ready = 1;
    do_start();
    n_cmp++;
    if ({overrun_o, ovr_cnt_o} !== 9'd0) begin
      n_err++; $display("FAIL t5_start_clear got ovr=%b cnt=%0d want 0 0", overrun_o, ovr_cnt_o);
    end
    wait_frame(1);
    repeat (20) @(negedge clk_i);
    #1; stop_i = 1'b1; stop_issued = 1;
    @(posedge clk_i); #1;
    n_cmp++;
    if ({busy_o, gen_rst_no} !== 2'b00) begin
      n_err++; $display("FAIL t5_stop_idle busy=%b gen=%b want 0 0", busy_o, gen_rst_no);
    end
    @(negedge clk_i); #1; stop_i = 1'b0;
    repeat (600) @(negedge clk_i);
    n_cmp++;
    if (obs_q.size() + exp_q.size() != 0) begin
      n_err++; $display("FAIL t5_no_words got %0d/%0d want 0", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_stop_run();
    bit okay = 0;
    lw = 24'h0C0FFE; rw = 24'hBEEF01; ready = 1;
    do_start();
    wait_frame(W + 1);
    repeat (40) @(negedge clk_i);
    do_stop();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i); #1;
      if (fs) begin okay = 1; break; end
    end
    n_cmp++;
    if (!okay || busy_o !== 1'b1) begin
      n_err++; $display("FAIL t4_drain_busy seen_fs=%b busy=%b want 1 1", okay, busy_o);
    end
    @(posedge clk_i); #1;
    n_cmp++;
    if ({busy_o, gen_rst_no} !== 2'b00) begin
      n_err++; $display("FAIL t4_idle_at_fs busy=%b gen=%b want 0 0", busy_o, gen_rst_no);
    end
    while (exp_q.size() > 0) begin
      wait_obs(1, ok);
      if (!ok) break;
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL t4_word got ch%b %h want ch%b %h", got[SW], got[SW-1:0], want[SW], want[SW-1:0]);
      end
    end
  endtask

  task automatic test_reset_midsession();
    bit okay = 0;
    lw = 24'h0F0F0F; rw = 24'hF0F0F0; ready = 0;
    do_start();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i); #1;
      if (sample_valid_o) begin okay = 1; break; end
    end
    n_cmp++;
    if (!okay) begin n_err++; $display("FAIL t6_valid_timeout valid=%b want 1", sample_valid_o); end
    repeat (5) @(negedge clk_i);
    #1; rst_ni = 1'b0;
    @(posedge clk_i); #1;
    n_cmp++;
    if ({gen_rst_no, busy_o, sample_valid_o, overrun_o, sample_ch_o, ovr_cnt_o, sample_o} !== '0) begin
      n_err++; $display("FAIL t6_reset_outputs gen=%b busy=%b v=%b s=%h want all 0",
                        gen_rst_no, busy_o, sample_valid_o, sample_o);
    end
    @(negedge clk_i); #1; rst_ni = 1'b1;
    exp_q.delete(); obs_q.delete();
    lw = 24'h3C3C3C; rw = 24'hC3C3C3; ready = 1;
    do_start();
    wait_frame(W);
    repeat (30) @(negedge clk_i);
    do_stop();
    while (exp_q.size() > 0) begin
      wait_obs(1, ok);
      if (!ok) break;
      got = obs_q.pop_front(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL t6_word got ch%b %h want ch%b %h", got[SW], got[SW-1:0], want[SW], want[SW-1:0]);
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_channels();
    test_overrun();
    test_stop_warmup();
    test_stop_run();
    test_reset_midsession();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
